// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
// Holds the arbiter FSM state encoding.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin winner selection, purely combinational.
// Prefers the lowest requester above last_grant, then wraps to the lowest.
module rr_pick #(
  parameter int LOG_REQ = 1
) (
  input  logic [2**LOG_REQ-1:0] req_i,
  input  logic [LOG_REQ-1:0]    last_grant_i,
  output logic [LOG_REQ-1:0]    winner_o,
  output logic                  any_o
);

  localparam int N = 2**LOG_REQ;

  logic               hi_found;
  logic [LOG_REQ-1:0] hi_idx;
  logic [LOG_REQ-1:0] lo_idx;

  // Descending scan so the lowest matching index is written last.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = LOG_REQ'(i);
        if (i > int'(last_grant_i)) begin
          hi_idx   = LOG_REQ'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign winner_o = hi_found ? hi_idx : lo_idx;
  assign any_o    = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter funnelling N requesters onto one memory port,
// with a single transaction outstanding at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOG_REQ = 1,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2**LOG_REQ-1:0]        req_valid,
  input  logic [2**LOG_REQ-1:0]        req_write,
  input  logic [2**LOG_REQ*ADDR_W-1:0] req_addr,
  input  logic [2**LOG_REQ*DATA_W-1:0] req_wdata,
  output logic [2**LOG_REQ-1:0]        req_ready,
  output logic [2**LOG_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]            resp_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_write,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_wdata,
  input  logic                        mem_req_ready,
  input  logic                        mem_resp_valid,
  input  logic [DATA_W-1:0]           mem_resp_data
);

  arb_state_t         state_q;
  logic [LOG_REQ-1:0] last_q;
  logic [LOG_REQ-1:0] owner_q;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [LOG_REQ-1:0] win;
  logic               any;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;

  rr_pick #(
    .LOG_REQ(LOG_REQ)
  ) u_pick (
    .req_i       (req_valid),
    .last_grant_i(last_q),
    .winner_o    (win),
    .any_o       (any)
  );

  assign addr_d  = req_addr[win*ADDR_W +: ADDR_W];
  assign wdata_d = req_wdata[win*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= '1;
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            owner_q <= win;
            write_q <= req_write[win];
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) state_q <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by reset so outputs drop immediately, not at the next edge.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    if (!reset && state_q == IDLE && any)
      req_ready[win] = 1'b1;
    if (!reset && state_q == WAIT_RESP && mem_resp_valid) begin
      resp_valid[owner_q] = 1'b1;
      resp_data           = mem_resp_data;
    end
  end

  assign mem_req_valid = !reset && state_q == ISSUE;
  assign mem_req_write = write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-requester and a
// 4-requester instance driven from hand-written vectors.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  logic [1:0]   rv2, wr2, rr2, rsv2;
  logic [127:0] a2, wd2;
  logic [63:0]  rd2, mad2, mwd2, mrd2;
  logic         mv2, mw2, mrdy2, mrv2;

  logic [3:0]   rv4, wr4, rr4, rsv4;
  logic [255:0] a4, wd4;
  logic [63:0]  rd4, mad4, mwd4, mrd4;
  logic         mv4, mw4, mrdy4, mrv4;

  int nvec;
  int nerr;

  mem_port_arbiter #(.LOG_REQ(1)) u2 (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (rv2),
    .req_write     (wr2),
    .req_addr      (a2),
    .req_wdata     (wd2),
    .req_ready     (rr2),
    .resp_valid    (rsv2),
    .resp_data     (rd2),
    .mem_req_valid (mv2),
    .mem_req_write (mw2),
    .mem_req_addr  (mad2),
    .mem_req_wdata (mwd2),
    .mem_req_ready (mrdy2),
    .mem_resp_valid(mrv2),
    .mem_resp_data (mrd2)
  );

  mem_port_arbiter #(.LOG_REQ(2)) u4 (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (rv4),
    .req_write     (wr4),
    .req_addr      (a4),
    .req_wdata     (wd4),
    .req_ready     (rr4),
    .resp_valid    (rsv4),
    .resp_data     (rd4),
    .mem_req_valid (mv4),
    .mem_req_write (mw4),
    .mem_req_addr  (mad4),
    .mem_req_wdata (mwd4),
    .mem_req_ready (mrdy4),
    .mem_resp_valid(mrv4),
    .mem_resp_data (mrd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b1;
    rv2 = '0; wr2 = '0; a2 = '0; wd2 = '0;
    mrdy2 = 1'b0; mrv2 = 1'b0; mrd2 = '0;
    rv4 = '0; wr4 = '0; a4 = '0; wd4 = '0;
    mrdy4 = 1'b0; mrv4 = 1'b0; mrd4 = '0;
    #2;
    chk("rst_ready", 64'(rr2), 64'h0);
    chk("rst_resp", 64'(rsv2), 64'h0);
    chk("rst_mreqv", 64'(mv2), 64'h0);
    chk("rst_maddr", mad2, 64'h0);
    cyc();
    cyc();
    reset = 1'b0;

    // Reset priority: requester 0 first, then 1
    a2 = {64'h40, 64'h10};
    cyc(); rv2 = 2'b11; mrdy2 = 1'b1;
    #1 chk("s1_ready0", 64'(rr2), 64'h1);
    cyc(); mrv2 = 1'b1; mrd2 = 64'h9999;
    #1 chk("s1_mreqv", 64'(mv2), 64'h1);
    chk("s1_maddr", mad2, 64'h10);
    chk("s1_noready", 64'(rr2), 64'h0);
    chk("s1_issue_resp", 64'(rsv2), 64'h0);
    cyc(); mrd2 = 64'h1111;
    #1 chk("s1_resp0", 64'(rsv2), 64'h1);
    chk("s1_rdata0", rd2, 64'h1111);
    cyc(); mrv2 = 1'b0;
    #1 chk("s1_ready1", 64'(rr2), 64'h2);
    cyc(); rv2 = 2'b00;
    #1 chk("s1_maddr1", mad2, 64'h40);
    cyc(); mrv2 = 1'b1; mrd2 = 64'h2222;
    #1 chk("s1_resp1", 64'(rsv2), 64'h2);
    cyc(); mrv2 = 1'b0;
    #1 chk("s1_idle_ready", 64'(rr2), 64'h0);
    chk("s1_idle_resp", 64'(rsv2), 64'h0);
    chk("s1_idle_rdata", rd2, 64'h0);

    // Single read from requester 1
    cyc(); rv2 = 2'b10; wr2 = 2'b00;
    #1 chk("s2_ready", 64'(rr2), 64'h2);
    cyc(); rv2 = 2'b00;
    #1 chk("s2_mreqv", 64'(mv2), 64'h1);
    chk("s2_maddr", mad2, 64'h40);
    chk("s2_mwrite", 64'(mw2), 64'h0);
    cyc(); mrv2 = 1'b1; mrd2 = 64'hDEAD;
    #1 chk("s2_resp", 64'(rsv2), 64'h2);
    chk("s2_rdata", rd2, 64'hDEAD);
    chk("s2_wait_mreqv", 64'(mv2), 64'h0);
    cyc(); mrv2 = 1'b0;
    #1 chk("s2_resp_off", 64'(rsv2), 64'h0);

    // Memory stall on a write from requester 0
    a2  = {64'h40, 64'h80};
    wd2 = {64'h0, 64'h1234};
    cyc(); rv2 = 2'b01; wr2 = 2'b01; mrdy2 = 1'b0;
    #1 chk("s3_ready", 64'(rr2), 64'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(); rv2 = 2'b11; wr2 = 2'b00;
      a2 = {64'h40, 64'hFF}; mrv2 = (i == 2);
      #1 chk("s3_stall_v", 64'(mv2), 64'h1);
      chk("s3_stall_a", mad2, 64'h80);
      chk("s3_stall_d", mwd2, 64'h1234);
      chk("s3_stall_rdy", 64'(rr2), 64'h0);
      chk("s3_stall_rsp", 64'(rsv2), 64'h0);
    end
    cyc(); mrdy2 = 1'b1; mrv2 = 1'b0;
    #1 chk("s3_last_v", 64'(mv2), 64'h1);
    chk("s3_write", 64'(mw2), 64'h1);
    cyc(); rv2 = 2'b00; mrv2 = 1'b1; mrd2 = 64'h5555;
    #1 chk("s3_resp", 64'(rsv2), 64'h1);
    chk("s3_rdata", rd2, 64'h5555);
    chk("s3_wait_rdy", 64'(rr2), 64'h0);
    chk("s3_wait_v", 64'(mv2), 64'h0);
    cyc(); mrv2 = 1'b0;

    // Stray response while idle
    cyc(); mrv2 = 1'b1; mrd2 = 64'hBEEF;
    #1 chk("s6_resp", 64'(rsv2), 64'h0);
    chk("s6_rdata", rd2, 64'h0);
    chk("s6_mreqv", 64'(mv2), 64'h0);
    cyc(); mrv2 = 1'b0;

    // Reset while waiting for the response
    cyc(); rv2 = 2'b10;
    #1 chk("s5_ready", 64'(rr2), 64'h2);
    cyc(); rv2 = 2'b00;
    cyc(); reset = 1'b1; mrv2 = 1'b1; mrd2 = 64'h7777;
    #1 chk("s5_rst_resp", 64'(rsv2), 64'h0);
    chk("s5_rst_rdata", rd2, 64'h0);
    chk("s5_rst_maddr", mad2, 64'h0);
    cyc(); reset = 1'b0;
    #1 chk("s5_post_resp", 64'(rsv2), 64'h0);
    cyc(); mrv2 = 1'b0; rv2 = 2'b11;
    #1 chk("s5_next_grant", 64'(rr2), 64'h1);
    cyc(); rv2 = 2'b00;
    cyc(); mrv2 = 1'b1;
    cyc(); mrv2 = 1'b0;

    // Round-robin across four requesters
    a4 = {64'h400, 64'h300, 64'h200, 64'h100};
    mrdy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0]  e;
      logic [63:0] ea;
      e  = 4'b0001 << (k % 4);
      ea = 64'((k % 4) + 1) << 8;
      cyc(); rv4 = 4'b1111; mrv4 = 1'b0;
      #1 chk("s4_grant", 64'(rr4), 64'(e));
      cyc();
      #1 chk("s4_maddr", mad4, ea);
      cyc(); mrv4 = 1'b1; mrd4 = 64'(k);
      #1 chk("s4_resp", 64'(rsv4), 64'(e));
      chk("s4_rdata", rd4, 64'(k));
    end
    cyc(); rv4 = '0; mrv4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
